vram_draw_engine: RTL
=====================

# vram_draw_engine

Pixel-drawing engine upstream of the VGA controller's 256x256 VRAM write port. It accepts drawing commands (fill rectangle, clear screen, plot point) through a valid/ready handshake. Commands are buffered in a small FIFO and rasterised at one pixel per clock. The block drives the controller's write_x/write_y/write_r/write_g/write_b inputs; the VRAM write enable there is tied high, so held outputs simply rewrite the same pixel.

## Interface
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- COORD_W, 8, coordinate width (256x256 VRAM)
- COLOR_W, 8, per-channel colour width
- iCLK  in  1  pixel clock (40 MHz, same as VGA controller)
- iRST  in  1  reset; one clock; reset is asynchronous and active-high
- iCmd_valid  in  1  command present
- oCmd_ready  out  1  FIFO can accept (= not full)
- iCmd_op  in  2  0 NOP, 1 RECT, 2 CLEAR, 3 POINT
- iX0, iY0, iX1, iY1  in  COORD_W each  corner coordinates
- iR, iG, iB  in  COLOR_W each  fill colour
- oWrite_x, oWrite_y  out  COORD_W each  to write_x/write_y
- oWrite_r, oWrite_g, oWrite_b  out  COLOR_W each  to write_r/g/b
- oWrite_en  out  1  new pixel this cycle (status/debug; VRAM ignores it)
- oBusy  out  1  FSM not IDLE or FIFO non-empty
- oDone  out  1  one-cycle pulse per completed RECT/CLEAR/POINT

## Operation
- Accept on the rising edge where iCmd_valid && oCmd_ready; the whole command word is pushed into the FIFO. oCmd_ready is low only when the FIFO is full; there is no bypass path.
- FSM states: IDLE, LOAD, FILL.
  - IDLE -> LOAD when the FIFO is non-empty. The head entry is popped into working registers.
  - LOAD normalises the coordinates:
    - xs=min(X0,X1), xe=max(X0,X1); ys, ye likewise.
    - CLEAR forces xs=ys=0 and xe=ye=255.
    - POINT forces xe=xs=X0 and ye=ys=Y0.
    - NOP: LOAD -> IDLE (or LOAD again if the FIFO is non-empty), with no writes and no oDone.
  - LOAD -> FILL with cx=xs, cy=ys.
  - FILL emits one pixel per cycle (cx, cy, colour) with oWrite_en=1. Raster order is x fastest: if cx==xe then cx=xs, cy++; otherwise cx++.
  - On the last pixel (cx==xe && cy==ye): go to LOAD if the FIFO is non-empty, else IDLE.
- Counters are COORD_W wide; no arithmetic overflows because xe,ye ≤ 255. CLEAR is 65536 cycles.
- Output registers hold their last value whenever oWrite_en=0.
- FIFO push while popping in the same cycle is allowed (not full). A push while full cannot occur because ready=0.
- Reset mid-FILL aborts the command, empties the FIFO and returns to IDLE. No oDone is produced for the aborted command.

## Timing
- Reset values:
  - oWrite_x/y/r/g/b = 0, oWrite_en = 0, oDone = 0, oBusy = 0.
  - oCmd_ready = 1, FSM = IDLE, FIFO empty.
  - After reset, pixel (0,0) is continuously rewritten black until the first command.
- Latency: command accepted at edge k into an empty FIFO with the FSM idle:
  - LOAD from edge k+1.
  - First pixel (oWrite_en=1) valid from edge k+2.
- N-pixel command: oWrite_en high for exactly N consecutive cycles.
- oDone is high for the single cycle after the last pixel.
- Back-to-back commands: exactly one LOAD cycle gap (oWrite_en=0) between the last pixel of one command and the first pixel of the next.
- oCmd_ready is combinational from the FIFO count. It rises in the cycle after a pop from full.

## Structure
- Package vram_draw_pkg:
  - op enum (OP_NOP/OP_RECT/OP_CLEAR/OP_POINT).
  - FSM state enum.
  - COORD_W/COLOR_W defaults.
  - Packed cmd_t struct {op, x0, y0, x1, y1, r, g, b}.
- One sub-module, draw_cmd_fifo: synchronous FIFO of cmd_t, depth FIFO_DEPTH, with full/empty flags, on iCLK/iRST.
- The FSM, normalisation and raster counters live in vram_draw_engine.

## Test plan
- Reset release, idle: oWrite_x/y/rgb=0, oWrite_en=0, oCmd_ready=1, oBusy=0.
- RECT X0=5,Y0=3,X1=2,Y1=4, colour (FF,00,80) accepted at edge k:
  - pixels (2,3),(3,3),(4,3),(5,3),(2,4)…(5,4) on edges k+2…k+9.
  - oDone at k+10.
  - oWrite_* hold (5,4,FF,00,80) afterwards.
- POINT (200,17) then RECT (0,0)-(1,0) pushed back-to-back:
  - one write at (200,17).
  - one-cycle gap, then (0,0),(1,0).
  - two oDone pulses.
- Fill FIFO with 4 RECTs while busy:
  - oCmd_ready=0 with a 5th iCmd_valid held; it is accepted only after the first pop.
  - all 5 commands complete in order.
- CLEAR colour (10,20,30): 65536 writes, last at (255,255), then oDone; a NOP queued behind it produces no writes and no oDone.
- Assert iRST mid-CLEAR with 2 queued commands: outputs return to reset values immediately; after release, no writes and oBusy=0.

Source files
------------

// File: rtl/vram_draw_pkg.sv
// Shared types for the VRAM draw engine: opcodes, FSM states
// and the packed command word carried through the FIFO.
package vram_draw_pkg;

  localparam int COORD_W = 8;
  localparam int COLOR_W = 8;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_RECT  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_POINT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FILL
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } cmd_t;

  function automatic logic [COORD_W-1:0] cmin(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] cmax(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/vram_draw_engine_if.sv
// Command handshake and VRAM write-port bundle of the draw engine.
// The engine takes the slave side, the command source the master side.
interface vram_draw_engine_if;
  import vram_draw_pkg::*;

  logic               iCmd_valid;
  logic               oCmd_ready;
  op_e                iCmd_op;
  logic [COORD_W-1:0] iX0;
  logic [COORD_W-1:0] iY0;
  logic [COORD_W-1:0] iX1;
  logic [COORD_W-1:0] iY1;
  logic [COLOR_W-1:0] iR;
  logic [COLOR_W-1:0] iG;
  logic [COLOR_W-1:0] iB;
  logic [COORD_W-1:0] oWrite_x;
  logic [COORD_W-1:0] oWrite_y;
  logic [COLOR_W-1:0] oWrite_r;
  logic [COLOR_W-1:0] oWrite_g;
  logic [COLOR_W-1:0] oWrite_b;
  logic               oWrite_en;
  logic               oBusy;
  logic               oDone;

  modport slave (
    input  iCmd_valid, iCmd_op,
    input  iX0, iY0, iX1, iY1,
    input  iR, iG, iB,
    output oCmd_ready,
    output oWrite_x, oWrite_y,
    output oWrite_r, oWrite_g, oWrite_b,
    output oWrite_en, oBusy, oDone
  );

  modport master (
    output iCmd_valid, iCmd_op,
    output iX0, iY0, iX1, iY1,
    output iR, iG, iB,
    input  oCmd_ready,
    input  oWrite_x, oWrite_y,
    input  oWrite_r, oWrite_g, oWrite_b,
    input  oWrite_en, oBusy, oDone
  );

endinterface

// File: rtl/draw_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on rdata
// whenever empty is low.
module draw_cmd_fifo
  import vram_draw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  always_ff @(posedge iCLK) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/vram_draw_engine.sv
// Rasterises queued RECT/CLEAR/POINT commands into the VRAM write
// port at one pixel per clock, x fastest.
module vram_draw_engine
  import vram_draw_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic iCLK,
  input logic iRST,
  vram_draw_engine_if.slave bus
);

  cmd_t   in_cmd;
  cmd_t   head;
  cmd_t   cmd;
  logic   full, empty, push, pop, last;
  state_e state;

  logic [COORD_W-1:0] xs, xe, ys, ye, cx, cy;
  logic [COORD_W-1:0] nxs, nxe, nys, nye, ncx, ncy;
  logic [COORD_W-1:0] wx, wy;
  logic [COLOR_W-1:0] wr, wg, wb;
  logic               wen, done;

  assign in_cmd = '{op: bus.iCmd_op,
                    x0: bus.iX0, y0: bus.iY0,
                    x1: bus.iX1, y1: bus.iY1,
                    r: bus.iR, g: bus.iG, b: bus.iB};

  assign push = bus.iCmd_valid && !full;
  assign last = (cx == xe) && (cy == ye);

  draw_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .push  (push),
    .wdata (in_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    pop = 1'b0;
    unique case (state)
      S_IDLE:  pop = !empty;
      S_LOAD:  pop = !empty && (cmd.op == OP_NOP);
      S_FILL:  pop = !empty && last;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    nxs = cmin(cmd.x0, cmd.x1);
    nxe = cmax(cmd.x0, cmd.x1);
    nys = cmin(cmd.y0, cmd.y1);
    nye = cmax(cmd.y0, cmd.y1);
    unique case (cmd.op)
      OP_CLEAR: begin
        nxs = '0; nxe = '1;
        nys = '0; nye = '1;
      end
      OP_POINT: begin
        nxs = cmd.x0; nxe = cmd.x0;
        nys = cmd.y0; nye = cmd.y0;
      end
      default: ;
    endcase
  end

  always_comb begin
    ncx = cx + COORD_W'(1);
    ncy = cy;
    if (cx == xe) begin
      ncx = xs;
      ncy = cy + COORD_W'(1);
    end
  end

  // The first pixel is emitted on the edge that leaves LOAD, so FILL
  // always holds the pixel currently presented on the write port.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= S_IDLE;
      cmd   <= '0;
      xs <= '0; xe <= '0; ys <= '0; ye <= '0;
      cx <= '0; cy <= '0;
      wx <= '0; wy <= '0;
      wr <= '0; wg <= '0; wb <= '0;
      wen  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          wen <= 1'b0;
          if (!empty) begin
            cmd   <= head;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cmd.op == OP_NOP) begin
            wen <= 1'b0;
            if (!empty) cmd <= head;
            else state <= S_IDLE;
          end else begin
            xs <= nxs; xe <= nxe;
            ys <= nys; ye <= nye;
            cx <= nxs; cy <= nys;
            wx <= nxs; wy <= nys;
            wr <= cmd.r; wg <= cmd.g; wb <= cmd.b;
            wen   <= 1'b1;
            state <= S_FILL;
          end
        end
        S_FILL: begin
          if (last) begin
            wen  <= 1'b0;
            done <= 1'b1;
            if (!empty) begin
              cmd   <= head;
              state <= S_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cx <= ncx; cy <= ncy;
            wx <= ncx; wy <= ncy;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.oCmd_ready = !full;
  assign bus.oBusy      = (state != S_IDLE) || !empty;
  assign bus.oWrite_x   = wx;
  assign bus.oWrite_y   = wy;
  assign bus.oWrite_r   = wr;
  assign bus.oWrite_g   = wg;
  assign bus.oWrite_b   = wb;
  assign bus.oWrite_en  = wen;
  assign bus.oDone      = done;

endmodule
